// File: rtl/multiplier_datapath_taint_track_word_if.sv
// multiplier_datapath_taint_track_word_if: controller-to-datapath bus for the taint-tracked shift-add multiplier
//   master: drives operands, control strobes and all input taints; samples multiplierReg and product outputs
//   slave : the datapath; samples operands and strobes; drives multiplierReg, product, product_valid and their taints
interface multiplier_datapath_taint_track_word_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0]   multiplicand;
    logic               multiplicand_t;
    logic [WIDTH-1:0]   multiplier;
    logic               multiplier_t;
    logic               mdld, mdld_t;
    logic               mrld, mrld_t;
    logic               rsclear, rsclear_t;
    logic               rsload, rsload_t;
    logic               rsshr, rsshr_t;
    logic               productDone, productDone_t;
    logic [WIDTH-1:0]   multiplierReg;
    logic               multiplierReg_t;
    logic [2*WIDTH-1:0] product;
    logic               product_t;
    logic               product_valid;
    logic               product_valid_t;

    modport master (
        output multiplicand, multiplicand_t, multiplier, multiplier_t,
               mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
        input  multiplierReg, multiplierReg_t, product, product_t,
               product_valid, product_valid_t
    );

    modport slave (
        input  multiplicand, multiplicand_t, multiplier, multiplier_t,
               mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
        output multiplierReg, multiplierReg_t, product, product_t,
               product_valid, product_valid_t
    );
endinterface

// File: rtl/multiplier_datapath_taint_track_word.sv
// multiplier_datapath_taint_track_word: shift-add multiplier datapath with one sticky taint bit per register
//   clk : clock, all state updates on posedge
//   rst : synchronous active-low reset
//   bus : slave side of the controller bus (operands, strobes and taints in; multiplierReg, product, product_valid and taints out)
module multiplier_datapath_taint_track_word #(
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic rst,
    multiplier_datapath_taint_track_word_if.slave bus
);
    logic [WIDTH-1:0]   md, mr;
    logic               md_t, mr_t;
    logic [2*WIDTH:0]   rs, rs_next;
    logic               rs_t, rs_t_next;
    logic [WIDTH:0]     rs_add;
    logic               st;
    logic [2*WIDTH-1:0] product;
    logic               product_t, product_valid, product_valid_t;

    // Upper half plus MD; the carry lands in the extra MSB of RS.
    assign rs_add = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};
    assign st     = bus.rsclear_t | bus.rsload_t | bus.rsshr_t;

    always_comb begin
        rs_next   = bus.rsclear ? '0
                  : bus.rsload  ? {rs_add, rs[WIDTH-1:0]}
                  : bus.rsshr   ? rs >> 1
                  : rs;
        // A tainted rsload strobe may have added MD, so MD's taint flows in.
        rs_t_next = bus.rsclear ? st
                  : rs_t | st | ((bus.rsload | bus.rsload_t) & md_t);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            md              <= '0;
            md_t            <= 1'b0;
            mr              <= '0;
            mr_t            <= 1'b0;
            rs              <= '0;
            rs_t            <= 1'b0;
            product         <= '0;
            product_t       <= 1'b0;
            product_valid   <= 1'b0;
            product_valid_t <= 1'b0;
        end else begin
            md              <= bus.mdld ? bus.multiplicand : md;
            md_t            <= bus.mdld ? (bus.multiplicand_t | bus.mdld_t) : (md_t | bus.mdld_t);
            mr              <= bus.mrld ? bus.multiplier : mr;
            mr_t            <= bus.mrld ? (bus.multiplier_t | bus.mrld_t) : (mr_t | bus.mrld_t);
            rs              <= rs_next;
            rs_t            <= rs_t_next;
            product         <= bus.productDone ? rs_next[2*WIDTH-1:0] : product;
            product_t       <= bus.productDone ? (rs_t_next | bus.productDone_t) : product_t;
            product_valid   <= bus.productDone;
            product_valid_t <= bus.productDone_t;
        end
    end

    assign bus.multiplierReg   = mr;
    assign bus.multiplierReg_t = mr_t;
    assign bus.product         = product;
    assign bus.product_t       = product_t;
    assign bus.product_valid   = product_valid;
    assign bus.product_valid_t = product_valid_t;
endmodule

// File: doc/multiplier_datapath_taint_track_word.md
# multiplier_datapath_taint_track_word

Word-level taint-tracking datapath for the sequential shift-add multiplier. It executes the strobes issued by the multiplier control FSM (mdld, mrld, rsclear, rsload, rsshr, productDone) and returns the multiplier register to the controller for bit testing. Each architectural register carries one taint bit, and every strobe carries its own taint, so the controller/datapath pair propagates taint end to end to the registered product output.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-low reset (rst==0 at a posedge resets)
- multiplicand  input  WIDTH  operand A
- multiplicand_t  input  1  taint of multiplicand
- multiplier  input  WIDTH  operand B
- multiplier_t  input  1  taint of multiplier
- mdld, mdld_t  input  1 each  load multiplicand register, and its taint
- mrld, mrld_t  input  1 each  load multiplier register, and its taint
- rsclear, rsclear_t  input  1 each  clear result register, and its taint
- rsload, rsload_t  input  1 each  add multiplicand into upper half of result, and its taint
- rsshr, rsshr_t  input  1 each  logical shift result right by 1, and its taint
- productDone, productDone_t  input  1 each  capture the final product, and its taint
- multiplierReg  output  WIDTH  multiplier register, to controller
- multiplierReg_t  output  1  taint of multiplierReg
- product  output  2*WIDTH  captured product
- product_t  output  1  taint of product
- product_valid  output  1  one-cycle pulse after capture
- product_valid_t  output  1  taint of product_valid

## Operation
- Internal state: MD[WIDTH-1:0] with md_t; MR[WIDTH-1:0] with mr_t; RS[2*WIDTH:0] with rs_t (the extra MSB holds the carry).
- Reset: MD, MR, RS, product, product_valid and all taints are set to 0. Reset overrides every strobe. It has the same effect mid-multiplication.
- MD: if mdld, MD <= multiplicand and md_t <= multiplicand_t | mdld_t. Otherwise MD holds and md_t <= md_t | mdld_t, because a tainted strobe may have loaded.
- MR: same rule using mrld, multiplier, multiplier_t and mrld_t. multiplierReg = MR and multiplierReg_t = mr_t.
- RS priority when strobes coincide: rsclear > rsload > rsshr.
  - rsclear: RS <= 0.
  - rsload: RS[2W:W] <= {1'b0, RS[2W-1:W]} + MD, a (W+1)-bit sum. RS[W-1:0] holds.
  - rsshr: RS <= RS >> 1, with 0 shifted into the MSB.
  - No strobe: RS holds.
- Taint propagation for RS, with st = rsclear_t | rsload_t | rsshr_t:
  - If rsclear: rs_t <= st.
  - Otherwise: rs_t <= rs_t | st | ((rsload | rsload_t) ? md_t : 0).
- Expected strobe sequence: mdld/mrld/rsclear together, then for each i = 0..W-1 one rsshr followed by rsload if MR[i] (else an idle cycle), then a final rsshr together with productDone.
  - The first shift operates on a cleared register and is harmless.
  - Result: RS[2W-1:0] = MD*MR.
- Capture: if productDone, product <= RS_next[2W-1:0], where RS_next is the value written into RS at the same edge (post-shift). product_t <= rs_t_next | productDone_t.
- product_valid <= productDone and product_valid_t <= productDone_t on every cycle.
- Outside a capture, product and product_t hold. Taint is sticky and is removed only by reset or a reload/clear with untainted sources.

## Timing
- All outputs are registered. There is no combinational path from the strobe inputs to any output.
- multiplierReg and multiplierReg_t reflect an mrld in the cycle after the load edge.
- A strobe applied at edge N is visible in RS, and in multiplierReg where relevant, from edge N onward.
- product, product_t and product_valid update at the productDone edge. product_valid is high for exactly one cycle unless productDone is held.
- Full WIDTH=4 multiply with the expected sequence: 1 init cycle + 2*W shift/load cycles + 1 final cycle = 10 cycles from the init strobes to the capture edge.
- Overflow cannot occur: the carry bit RS[2W] absorbs every addition and is shifted down on the next rsshr.

## Test plan
- Reset: hold rst=0 for 2 cycles with random strobes asserted. Required: all outputs and taints read 0; after release, state holds with no strobes.
- Untainted 13×11, WIDTH=4: drive the expected strobe sequence. Required: product = 8'h8F (143), product_t=0, product_valid high for one cycle at the capture edge.
- Carry path 15×15: required product = 8'hE1 (225). Zero case 0×9: required product = 8'h00.
- Taint propagation: load with multiplicand_t=1, otherwise untainted, and MR=4'b0000 so rsload never fires. Required: multiplierReg_t=0 and product_t=0. Repeat with MR=4'b0001: required product_t=1. Repeat with a tainted rsshr_t pulse during an idle cycle: required product_t=1.
- Priority and clear: assert rsclear, rsload and rsshr together with a nonzero RS. Required: RS=0, and rs_t = st only, discarding a prior rs_t=1. Assert rsload and rsshr together. Required: load only, no shift.
- Reset mid-operation: assert rst=0 after the third rsload of a 15×15 run. Required: all registers and taints are 0 at the next edge, and a fresh 3×5 run yields product = 8'h0F.
